// File: rtl/mac2phy_os_detector_if.sv
// mac2phy_os_detector_if: MAC transmit byte lane (data, K flag, valid)
interface mac2phy_os_detector_if;
    logic [7:0] txdata;
    logic       txdatak;
    logic       txvalid;
    modport master (output txdata, txdatak, txvalid);
    modport slave  (input  txdata, txdatak, txvalid);
endinterface

// File: rtl/mac2phy_os_detector.sv
// mac2phy_os_detector: recognises SKP/TS1/TS2 ordered sets on the MAC transmit byte lane
// Optional LTSSM-state filter: define M2P_LTSSM_FILTER_EN
package ozdefs;
    localparam logic [7:0] COM   = 8'hBC;
    localparam logic [7:0] SKP   = 8'h1C;
    localparam logic [7:0] PAD   = 8'hF7;
    localparam logic [7:0] TS1ID = 8'h4A;
    localparam logic [7:0] TS2ID = 8'h45;
    typedef enum logic [3:0] {
        DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE, POLLING_ACTIVE_START_TS1,
        POLLING_CONFIG, POLLING_COMPLIANCE, CONFIG_LINKWIDTH_START, L0
    } LTSSM_State;
endpackage

module mac2phy_os_detector
    import ozdefs::*;
(
    input  logic                   clk,
    input  logic                   m2pd_rstn,
    input  LTSSM_State             currLtssmState,
    mac2phy_os_detector_if.slave   tx,
    output logic                   skpDetected,
    output logic                   ts1Detected,
    output logic                   ts2Detected,
    output logic [39:0]            tsBytes1Thru5,
    output logic [3:0]             consecTs1Count,
    output logic [3:0]             consecTs2Count,
    output logic                   osError,
    output logic                   unexpectedOs
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_SKP, S_TS} state_t;

    state_t      r_state, w_state_n;
    logic [3:0]  r_idx, w_idx_n;
    logic [1:0]  r_skp_cnt, w_skp_cnt_n;
    logic [39:0] r_shadow, w_shadow_n;
    logic        r_ts2, w_ts2_n, r_last_ts2;
    logic        w_com, w_err, w_skp_done, w_ts_done;
    logic        w_ok_skp, w_ok_ts1, w_ok_ts2, w_clr;
    logic        w_ts_ok, w_unexp, w_same;
    logic [3:0]  w_c1_inc, w_c2_inc;

    assign w_com = tx.txdatak && tx.txdata == COM;

`ifdef M2P_LTSSM_FILTER_EN
    LTSSM_State r_prev_state;
    // Track the LTSSM state so a change can clear the consecutive counts
    always_ff @(posedge clk or negedge m2pd_rstn)
        if (!m2pd_rstn) r_prev_state <= DETECT_QUIET;
        else            r_prev_state <= currLtssmState;
    assign w_clr    = currLtssmState != r_prev_state;
    assign w_ok_skp = currLtssmState == POLLING_ACTIVE;
    assign w_ok_ts1 = currLtssmState == POLLING_ACTIVE_START_TS1;
    assign w_ok_ts2 = currLtssmState == POLLING_CONFIG;
`else
    logic w_unused_state;
    assign w_unused_state = ^currLtssmState;
    assign w_clr    = 1'b0;
    assign w_ok_skp = 1'b1;
    assign w_ok_ts1 = 1'b1;
    assign w_ok_ts2 = 1'b1;
`endif

    // Next-state: walk the ordered set byte by byte; a stray K COM restarts at the header
    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_skp_cnt_n = r_skp_cnt;
        w_shadow_n  = r_shadow;
        w_ts2_n     = r_ts2;
        w_err       = 1'b0;
        w_skp_done  = 1'b0;
        w_ts_done   = 1'b0;
        if (tx.txvalid) begin
            case (r_state)
                S_IDLE: if (w_com) begin
                    w_state_n = S_HDR;
                    w_idx_n   = 4'd1;
                end
                S_HDR: begin
                    if (tx.txdatak && tx.txdata == SKP) begin
                        w_state_n   = S_SKP;
                        w_skp_cnt_n = 2'd1;
                        w_idx_n     = 4'd2;
                    end else if (!tx.txdatak || tx.txdata == PAD) begin
                        w_state_n  = S_TS;
                        w_shadow_n = {tx.txdata, r_shadow[39:8]};
                        w_idx_n    = 4'd2;
                    end else
                        w_err = 1'b1;
                end
                S_SKP: begin
                    if (tx.txdatak && tx.txdata == SKP) begin
                        w_skp_cnt_n = r_skp_cnt + 2'd1;
                        w_idx_n     = r_idx + 4'd1;
                        w_skp_done  = r_skp_cnt == 2'd2;
                    end else
                        w_err = 1'b1;
                end
                default: begin
                    if (r_idx <= 4'd5) begin
                        if (!tx.txdatak || tx.txdata == PAD) begin
                            w_shadow_n = {tx.txdata, r_shadow[39:8]};
                            w_idx_n    = r_idx + 4'd1;
                        end else
                            w_err = 1'b1;
                    end else if (r_idx == 4'd6) begin
                        if (!tx.txdatak && (tx.txdata == TS1ID || tx.txdata == TS2ID)) begin
                            w_ts2_n = tx.txdata == TS2ID;
                            w_idx_n = r_idx + 4'd1;
                        end else
                            w_err = 1'b1;
                    end else if (!tx.txdatak && tx.txdata == (r_ts2 ? TS2ID : TS1ID)) begin
                        w_idx_n   = r_idx + 4'd1;
                        w_ts_done = r_idx == 4'd15;
                    end else
                        w_err = 1'b1;
                end
            endcase
            if (w_skp_done || w_ts_done) begin
                w_state_n = S_IDLE;
                w_idx_n   = 4'd0;
            end
            if (w_err) begin
                w_state_n = w_com ? S_HDR : S_IDLE;
                w_idx_n   = w_com ? 4'd1 : 4'd0;
            end
        end
    end

    assign w_ts_ok  = w_ts_done && (r_ts2 ? w_ok_ts2 : w_ok_ts1);
    assign w_unexp  = (w_ts_done && !w_ts_ok) || (w_skp_done && !w_ok_skp);
    assign w_same   = r_last_ts2 == r_ts2 && tsBytes1Thru5 == r_shadow;
    assign w_c1_inc = consecTs1Count + {3'b0, consecTs1Count != 4'hF};
    assign w_c2_inc = consecTs2Count + {3'b0, consecTs2Count != 4'hF};

    // Parser state registers
    always_ff @(posedge clk or negedge m2pd_rstn) begin
        if (!m2pd_rstn) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_skp_cnt <= 2'd0;
            r_shadow  <= 40'd0;
            r_ts2     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_skp_cnt <= w_skp_cnt_n;
            r_shadow  <= w_shadow_n;
            r_ts2     <= w_ts2_n;
        end
    end

    // Registered report: pulses, last accepted TS bytes and consecutive counts
    always_ff @(posedge clk or negedge m2pd_rstn) begin
        if (!m2pd_rstn) begin
            skpDetected    <= 1'b0;
            ts1Detected    <= 1'b0;
            ts2Detected    <= 1'b0;
            osError        <= 1'b0;
            unexpectedOs   <= 1'b0;
            tsBytes1Thru5  <= 40'd0;
            r_last_ts2     <= 1'b0;
            consecTs1Count <= 4'd0;
            consecTs2Count <= 4'd0;
        end else begin
            skpDetected  <= w_skp_done && w_ok_skp;
            ts1Detected  <= w_ts_ok && !r_ts2;
            ts2Detected  <= w_ts_ok && r_ts2;
            osError      <= w_err;
            unexpectedOs <= w_unexp;
            if (w_ts_ok) begin
                tsBytes1Thru5 <= r_shadow;
                r_last_ts2    <= r_ts2;
            end
            if (w_clr) begin
                consecTs1Count <= 4'd0;
                consecTs2Count <= 4'd0;
            end else if (w_ts_ok) begin
                consecTs1Count <= r_ts2 ? (w_same ? consecTs1Count : 4'd0) : (w_same ? w_c1_inc : 4'd1);
                consecTs2Count <= r_ts2 ? (w_same ? w_c2_inc : 4'd1) : (w_same ? consecTs2Count : 4'd0);
            end
        end
    end
endmodule

// File: tb/tb_mac2phy_os_detector.sv
// tb_mac2phy_os_detector: scoreboard bench for the ordered-set detector
module tb_mac2phy_os_detector;
    import ozdefs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    LTSSM_State  st = POLLING_ACTIVE;
    logic        skpDetected, ts1Detected, ts2Detected, osError, unexpectedOs;
    logic [39:0] tsBytes1Thru5;
    logic [3:0]  consecTs1Count, consecTs2Count;

    mac2phy_os_detector_if bus();

    mac2phy_os_detector dut (
        .clk            (clk),
        .m2pd_rstn      (rst_n),
        .currLtssmState (st),
        .tx             (bus),
        .skpDetected    (skpDetected),
        .ts1Detected    (ts1Detected),
        .ts2Detected    (ts2Detected),
        .tsBytes1Thru5  (tsBytes1Thru5),
        .consecTs1Count (consecTs1Count),
        .consecTs2Count (consecTs2Count),
        .osError        (osError),
        .unexpectedOs   (unexpectedOs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        skp, ts1, ts2, err, unexp;
        logic [39:0] b;
        logic [3:0]  c1, c2;
    } ev_t;

    ev_t         q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [39:0] m_b  = '0;
    logic [3:0]  m_c1 = '0;
    logic [3:0]  m_c2 = '0;
    logic        m_l2 = 1'b0;

    // Scoreboard: every pulse cycle must match the oldest expected event
    always @(negedge clk) begin : mon
        ev_t got, exp;
        if (rst_n && (skpDetected || ts1Detected || ts2Detected || osError || unexpectedOs)) begin
            got = {skpDetected, ts1Detected, ts2Detected, osError, unexpectedOs,
                   tsBytes1Thru5, consecTs1Count, consecTs2Count};
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL event: stray pulse skp/ts1/ts2/err/unexp=%b%b%b%b%b b=%h c1=%0d c2=%0d, none required",
                         got.skp, got.ts1, got.ts2, got.err, got.unexp, got.b, got.c1, got.c2);
            end else begin
                exp = q.pop_front();
                if (got !== exp)
                begin
                    fails++;
                    $display("FAIL event: got skp/ts1/ts2/err/unexp=%b%b%b%b%b b=%h c1=%0d c2=%0d required %b%b%b%b%b b=%h c1=%0d c2=%0d",
                             got.skp, got.ts1, got.ts2, got.err, got.unexp, got.b, got.c1, got.c2,
                             exp.skp, exp.ts1, exp.ts2, exp.err, exp.unexp, exp.b, exp.c1, exp.c2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // t: 0=SKP, 1=TS1, 2=TS2
    function automatic logic exp_ok(input int t);
`ifdef M2P_LTSSM_FILTER_EN
        return (t == 0 && st == POLLING_ACTIVE) || (t == 1 && st == POLLING_ACTIVE_START_TS1) ||
               (t == 2 && st == POLLING_CONFIG);
`else
        return t inside {0, 1, 2};
`endif
    endfunction

    task automatic push_ev(input logic skp, input logic ts1, input logic ts2, input logic err, input logic unexp);
        q.push_back({skp, ts1, ts2, err, unexp, m_b, m_c1, m_c2});
    endtask

    task automatic exp_skp();
        if (exp_ok(0)) push_ev(1, 0, 0, 0, 0);
        else           push_ev(0, 0, 0, 0, 1);
    endtask

    task automatic exp_err();
        push_ev(0, 0, 0, 1, 0);
    endtask

    task automatic exp_ts(input logic [39:0] b, input logic is2);
        if (exp_ok(is2 ? 2 : 1)) begin
            if (m_l2 == is2 && m_b == b) begin
                if (is2) m_c2 = (m_c2 == 4'hF) ? m_c2 : m_c2 + 4'd1;
                else     m_c1 = (m_c1 == 4'hF) ? m_c1 : m_c1 + 4'd1;
            end else begin
                m_c1 = is2 ? 4'd0 : 4'd1;
                m_c2 = is2 ? 4'd1 : 4'd0;
            end
            m_b  = b;
            m_l2 = is2;
            push_ev(0, !is2, is2, 0, 0);
        end else
            push_ev(0, 0, 0, 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic k, input int gap);
        @(negedge clk);
        bus.txdata  = d;
        bus.txdatak = k;
        bus.txvalid = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            bus.txvalid = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.txvalid = 1'b0;
    endtask

    task automatic send_ts(input logic [39:0] b, input logic is2, input int gap);
        send(COM, 1'b1, gap);
        for (int i = 0; i < 5; i++) send(b[8*i +: 8], 1'b0, gap);
        for (int i = 6; i <= 15; i++) begin
            if (i == 15) exp_ts(b, is2);
            send(is2 ? TS2ID : TS1ID, 1'b0, gap);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_state(input LTSSM_State s);
        @(negedge clk);
`ifdef M2P_LTSSM_FILTER_EN
        if (s != st) begin
            m_c1 = 4'd0;
            m_c2 = 4'd0;
        end
`endif
        st = s;
        bus.txvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.txvalid = 1'b0;
        q.delete();
        m_b = '0; m_c1 = '0; m_c2 = '0; m_l2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.txdata = '0; bus.txdatak = 1'b0; bus.txvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({skpDetected, ts1Detected, ts2Detected, osError, unexpectedOs} !== 5'b0) begin
            fails++; $display("FAIL reset_pulses: got %b required 00000",
                              {skpDetected, ts1Detected, ts2Detected, osError, unexpectedOs});
        end
        checks++;
        if (tsBytes1Thru5 !== 40'd0) begin
            fails++; $display("FAIL reset_bytes: got %h required 0", tsBytes1Thru5);
        end
        checks++;
        if ({consecTs1Count, consecTs2Count} !== 8'd0) begin
            fails++; $display("FAIL reset_counts: got %0d/%0d required 0/0", consecTs1Count, consecTs2Count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_skp();
        set_state(POLLING_ACTIVE);
        send(COM, 1'b1, 0);
        send(SKP, 1'b1, 0);
        send(SKP, 1'b1, 0);
        exp_skp();
        send(SKP, 1'b1, 0);
        idle();
        drain();
        checks++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL skp_drain: %0d events outstanding, required 0", q.size());
        end
    endtask

    task automatic test_repeated_ts1();
        set_state(POLLING_ACTIVE_START_TS1);
        repeat (8) send_ts(40'h0504030201, 1'b0, 0);
        idle();
        drain();
        checks++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL rep_drain: %0d events outstanding, required 0", q.size());
        end
        checks++;
        if (tsBytes1Thru5 !== 40'h0504030201) begin
            fails++; $display("FAIL rep_bytes: got %h required 0504030201", tsBytes1Thru5);
        end
        checks++;
        if (consecTs1Count !== 4'd8) begin
            fails++; $display("FAIL rep_count: got %0d required 8", consecTs1Count);
        end
    endtask

    task automatic test_bytes_change();
        repeat (3) send_ts(40'h1514131211, 1'b0, 0);
        idle();
        drain();
        checks++;
        if (consecTs1Count !== 4'd3) begin
            fails++; $display("FAIL chg_count3: got %0d required 3", consecTs1Count);
        end
        send_ts(40'h1514AA1211, 1'b0, 0);
        idle();
        drain();
        checks++;
        if (consecTs1Count !== 4'd1) begin
            fails++; $display("FAIL chg_count1: got %0d required 1", consecTs1Count);
        end
        send_ts(40'h2524232221, 1'b1, 0);
        idle();
        drain();
        checks++;
        if ({consecTs1Count, consecTs2Count} !== {m_c1, m_c2}) begin
            fails++; $display("FAIL chg_ts2: got c1=%0d c2=%0d required c1=%0d c2=%0d",
                              consecTs1Count, consecTs2Count, m_c1, m_c2);
        end
    endtask

    task automatic test_mismatch();
        send(COM, 1'b1, 0);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 0);
        for (int i = 6; i <= 9; i++) send(TS2ID, 1'b0, 0);
        exp_err();
        send(TS1ID, 1'b0, 0);
        idle();
        drain();
        checks++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL mis_corrupt: %0d events outstanding, required 0", q.size());
        end
        send(COM, 1'b1, 0);
        for (int i = 1; i <= 5; i++) send(8'(i + 8'h30), 1'b0, 0);
        send(TS1ID, 1'b0, 0);
        send(TS1ID, 1'b0, 0);
        exp_err();
        send(COM, 1'b1, 0);
        for (int i = 0; i < 5; i++) send(8'(i + 8'h41), 1'b0, 0);
        for (int i = 6; i <= 15; i++) begin
            if (i == 15) exp_ts(40'h4544434241, 1'b0);
            send(TS1ID, 1'b0, 0);
        end
        idle();
        drain();
        checks++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL mis_restart: %0d events outstanding, required 0", q.size());
        end
    endtask

    task automatic test_gaps();
        send_ts(40'h0A09080706, 1'b0, 3);
        idle();
        drain();
        checks++;
        if (tsBytes1Thru5 !== m_b) begin
            fails++; $display("FAIL gap_bytes: got %h required %h", tsBytes1Thru5, m_b);
        end
        checks++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL gap_drain: %0d events outstanding, required 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        send(COM, 1'b1, 0);
        for (int i = 0; i < 6; i++) send(8'h77, 1'b0, 0);
        do_reset();
        checks++;
        if ({tsBytes1Thru5, consecTs1Count, consecTs2Count} !== 48'd0) begin
            fails++; $display("FAIL rstmid_state: got b=%h c1=%0d c2=%0d required zeros",
                              tsBytes1Thru5, consecTs1Count, consecTs2Count);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) send(TS1ID, 1'b0, 0);
        send_ts(40'h0102030405, 1'b0, 0);
        idle();
        drain();
        checks++;
        if (consecTs1Count !== m_c1) begin
            fails++; $display("FAIL rstmid_count: got %0d required %0d", consecTs1Count, m_c1);
        end
    endtask

`ifdef M2P_LTSSM_FILTER_EN
    task automatic test_filter();
        set_state(POLLING_ACTIVE_START_TS1);
        send_ts(40'h3333333333, 1'b0, 0);
        send_ts(40'h3333333333, 1'b1, 0);
        idle();
        drain();
        checks++;
        if ({consecTs1Count, consecTs2Count, tsBytes1Thru5} !== {4'd1, 4'd0, 40'h3333333333}) begin
            fails++; $display("FAIL filt_unchanged: got c1=%0d c2=%0d b=%h required 1/0/3333333333",
                              consecTs1Count, consecTs2Count, tsBytes1Thru5);
        end
        set_state(POLLING_CONFIG);
        checks++;
        if ({consecTs1Count, consecTs2Count} !== 8'd0) begin
            fails++; $display("FAIL filt_clear: got %0d/%0d required 0/0", consecTs1Count, consecTs2Count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_skp();
        test_repeated_ts1();
        test_bytes_change();
        test_mismatch();
        test_gaps();
        test_reset_mid();
`ifdef M2P_LTSSM_FILTER_EN
        test_filter();
`endif
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
